prach_hbd_ch: RTL and testbench
===============================

Name: prach_hbd_ch

Overview:
- Parametrised multi-channel TDM half-band decimate-by-2 filter for the PRACH long-sequence decimation chain.
- Inputs arrive pre-split into two polyphase branches:
  - dp1: centre-tap phase.
  - dp2: odd-tap phase.
- Produces one filtered output per input slot.
- Generalises the fixed 32-channel, 4-tap stage with: configurable width, channel count and tap count; valid qualification; bypass mode; output saturation with a sticky overflow flag.

Parameters:
- NUM_CH, 32, number of TDM channels interleaved on the bus (2..64).
- NUM_UNIQ, 2, unique odd-phase coefficients; odd-phase taps = 2*NUM_UNIQ (1..4).
- DW, 16, signed data width of inputs and output.
- CW, 18, coefficient width, fi(1,CW,CW-1).
- COE, '{-4249, 37013}, unique coefficients C0..C(NUM_UNIQ-1), outermost tap first.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- bypass  in  1  1 = pass dp1 unfiltered; sampled with each valid input slot
- din_valid  in  1  qualifies din_* and advances the filter history
- din_dp1  in  DW  centre-phase sample, signed
- din_dp2  in  DW  odd-phase sample, signed
- din_chn  in  8  channel index of the current slot
- sync_in  in  1  frame/sync marker, travels with data
- dout_valid  out  1  output qualifier
- dout_dq  out  DW  filtered sample, signed
- dout_chn  out  8  channel index of dout_dq
- sync_out  out  1  sync marker aligned to dout
- ovf_clr  in  1  synchronous clear of ovf_sticky
- ovf_sticky  out  1  set when any output saturated since the last clear/reset

Behaviour:
- Channel ordering: data is TDM, one slot per valid cycle, channel order repeating with period NUM_CH. din_chn is carried only; it is not used for addressing.
- History storage:
  - dp2 delay line: depth (2*NUM_UNIQ-1)*NUM_CH+1.
  - dp1 delay line: depth (NUM_UNIQ-1)*NUM_CH plus the alignment needed for the fixed latency.
  - Both lines shift only on din_valid, so tap spacing is exactly NUM_CH valid slots.
  - Gaps in din_valid must not change any output value.
- Filter function: for channel c, per-channel sample index n, with x2 = dp2 and x1 = dp1:
  - acc = sum_{k=0..U-1} COE[k]*(x2[n-k] + x2[n-(2U-1-k)]) + x1[n-(U-1)]*2^(CW-2), where U = NUM_UNIQ.
- Arithmetic:
  - Pre-add is DW+1 bits; products are DW+CW+1 bits.
  - Accumulator is DW+CW+clog2(U)+2 bits; no intermediate wrap.
  - Output = (acc + 2^(CW-2)) >>> (CW-1), i.e. round-half-up.
  - The result is then saturated to [-2^(DW-1), 2^(DW-1)-1].
- Overflow flag:
  - ovf_sticky sets on the cycle a saturated sample is presented with dout_valid=1.
  - ovf_clr clears it on the next edge.
  - If saturation and ovf_clr occur in the same cycle, set wins.
- Bypass: bypass is captured with its slot. For that slot, dout_dq = din_dp1 of the same slot and ovf is unaffected. History still updates, so leaving bypass needs no flush.
- Latency: fixed 6 clk from a valid input slot to its dout_valid.
  - dout_valid, dout_chn and sync_out are the respective inputs delayed exactly 6 cycles.
  - din_valid=0 slots produce dout_valid=0, with dout_dq held.
  - sync_in is delayed regardless of din_valid.
- Reset (async on rst_n low, immediate):
  - dout_valid=0, dout_dq=0, dout_chn=0, sync_out=0, ovf_sticky=0.
  - All pipeline valid/sync stages are cleared.
  - Delay-line contents are not reset (MLAB storage). dout_dq values are don't-care until (2U-1)*NUM_CH+1 valid slots have been accepted after reset; dout_valid still follows din_valid.
  - Reset mid-stream drops all in-flight samples.

Test Plan (defaults):
- Impulse: ch5 dp2=16384 in one slot, all else 0 -> ch5 outputs at per-channel indices n..n+3 = -531, 4627, 4627, -531; other channels 0.
- Centre tap: ch0 dp1=16384 once -> ch0 output 8192 at per-channel index n+1; others 0.
- DC: dp1=dp2=10000 on all channels, continuous valid -> steady-state dout_dq=9999 on every channel; ovf_sticky=0.
- Saturation: ch3 dp1=32767 constant; dp2 sequence -32768, 32767, 32767, -32768 -> at index n+3 dout_dq=32767 (unsaturated 37014) and ovf_sticky=1; ovf_clr pulse -> 0 next cycle.
- Gaps: the DC and impulse streams with random din_valid=0 gaps (~30%) -> dout values identical to the gap-free run; dout_valid equals din_valid delayed 6; dout_chn/sync_out aligned.
- Bypass/reset: bypass=1, dp1=1234 -> dout_dq=1234 six cycles later. Then assert rst_n=0 mid-stream -> dout_valid, sync_out, ovf_sticky go 0 immediately; after release, dout_valid resumes 6 cycles after the first valid input.

Source files
------------

// File: rtl/prach_hbd_ch.sv
// prach_hbd_ch: multi-channel TDM half-band decimate-by-2 filter stage.
// The input arrives as two polyphase branches: dp1 carries the centre tap and
// dp2 the symmetric odd taps. Channels are interleaved, so taps of the same
// channel sit NUM_CH valid slots apart. Fixed latency of 6 clocks from a
// valid input slot to its output; bypass slots return dp1 unfiltered.
module prach_hbd_ch #(
  parameter int NUM_CH        = 32,
  parameter int NUM_UNIQ      = 2,
  parameter int DW            = 16,
  parameter int CW            = 18,
  parameter int COE [NUM_UNIQ] = '{-4249, 37013}
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          bypass,
  input  logic          din_valid,
  input  logic [DW-1:0] din_dp1,
  input  logic [DW-1:0] din_dp2,
  input  logic [7:0]    din_chn,
  input  logic          sync_in,
  output logic          dout_valid,
  output logic [DW-1:0] dout_dq,
  output logic [7:0]    dout_chn,
  output logic          sync_out,
  input  logic          ovf_clr,
  output logic          ovf_sticky
);

  localparam int U    = NUM_UNIQ;
  localparam int NT   = 2 * U;
  localparam int D2   = (NT - 1) * NUM_CH + 1;
  localparam int D1   = (U - 1) * NUM_CH + 1;
  localparam int PW   = DW + 1;
  localparam int MW   = DW + CW + 1;
  localparam int AW   = DW + CW + $clog2(U) + 2;
  localparam int LAT  = 6;
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (CW - 2));
  localparam logic signed [AW-1:0] MAXV = AW'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW-1:0] MINV = -MAXV - AW'(1);

  // History lines; index 0 holds the newest accepted sample
  logic signed [DW-1:0] d2_q [D2];
  logic signed [DW-1:0] d1_q [D1];

  // Pipeline data (not reset: values are qualified by the valid pipe)
  logic signed [PW-1:0] pre_q  [U];
  logic signed [MW-1:0] prod_q [U];
  logic signed [DW-1:0] ctr1_q, ctr2_q;
  logic signed [DW-1:0] bdat1_q, bdat2_q, bdat3_q, bdat4_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] rnd_d;
  logic signed [DW-1:0] res_q, res_d;
  logic                 sat_q, sat_d;
  logic signed [CW-1:0] coe_w [U];

  // Control pipeline and outputs (reset)
  logic [LAT-1:0] vld_q, syn_q, byp_q;
  logic [7:0]     chn_q [LAT];
  logic [DW-1:0]  dq_q;
  logic           ovf_q, ovf_set;

  // Coefficients narrowed to the fi(1,CW,CW-1) format
  always_comb begin
    for (int k = 0; k < U; k++) coe_w[k] = CW'(COE[k]);
  end

  // Shift both history lines only on accepted slots so gaps are transparent
  always_ff @(posedge clk) begin
    if (din_valid) begin
      d2_q[0] <= din_dp2;
      for (int i = 1; i < D2; i++) d2_q[i] <= d2_q[i-1];
      d1_q[0] <= din_dp1;
      for (int i = 1; i < D1; i++) d1_q[i] <= d1_q[i-1];
    end
  end

  // Arithmetic pipeline: symmetric pre-add, multiply, then accumulate
  always_ff @(posedge clk) begin
    for (int k = 0; k < U; k++) begin
      pre_q[k]  <= PW'(d2_q[k*NUM_CH]) + PW'(d2_q[(NT-1-k)*NUM_CH]);
      prod_q[k] <= MW'(pre_q[k]) * MW'(coe_w[k]);
    end
    ctr1_q  <= d1_q[D1-1];
    ctr2_q  <= ctr1_q;
    bdat1_q <= d1_q[0];
    bdat2_q <= bdat1_q;
    bdat3_q <= bdat2_q;
    bdat4_q <= bdat3_q;
    acc_q   <= acc_d;
    res_q   <= res_d;
    sat_q   <= sat_d;
  end

  // Sum of tap products plus the centre tap scaled by 2^(CW-2)
  always_comb begin
    acc_d = AW'(ctr2_q) <<< (CW - 2);
    for (int k = 0; k < U; k++) acc_d = acc_d + AW'(prod_q[k]);
  end

  // Round half up, then saturate to the output range and flag clipping
  always_comb begin
    rnd_d = (acc_q + HALF) >>> (CW - 1);
    sat_d = 1'b0;
    res_d = DW'(rnd_d);
    if (rnd_d > MAXV) begin
      res_d = DW'(MAXV);
      sat_d = 1'b1;
    end else if (rnd_d < MINV) begin
      res_d = DW'(MINV);
      sat_d = 1'b1;
    end
  end

  // A clipped filtered sample reaching the output wins over a clear request
  assign ovf_set = vld_q[LAT-2] && !byp_q[LAT-2] && sat_q;

  // Control delay line, output register and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      syn_q <= '0;
      byp_q <= '0;
      for (int i = 0; i < LAT; i++) chn_q[i] <= '0;
      dq_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      vld_q    <= {vld_q[LAT-2:0], din_valid};
      syn_q    <= {syn_q[LAT-2:0], sync_in};
      byp_q    <= {byp_q[LAT-2:0], bypass};
      chn_q[0] <= din_chn;
      for (int i = 1; i < LAT; i++) chn_q[i] <= chn_q[i-1];
      if (vld_q[LAT-2]) dq_q <= byp_q[LAT-2] ? bdat4_q : res_q;
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  assign dout_valid = vld_q[LAT-1];
  assign sync_out   = syn_q[LAT-1];
  assign dout_chn   = chn_q[LAT-1];
  assign dout_dq    = dq_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_prach_hbd_ch.sv
// tb_prach_hbd_ch: directed and randomized stimulus for prach_hbd_ch, checked
// against a slot-history model of the half-band filter equation.
module tb_prach_hbd_ch;

   localparam int N  = 32;
   localparam int U  = 2;
   localparam int DW = 16;
   localparam int CW = 18;
   localparam int COE [U] = '{-4249, 37013};

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          bypass = 1'b0;
   logic          din_valid = 1'b0;
   logic [DW-1:0] din_dp1 = '0;
   logic [DW-1:0] din_dp2 = '0;
   logic [7:0]    din_chn = '0;
   logic          sync_in = 1'b0;
   logic          ovf_clr = 1'b0;
   logic          dout_valid;
   logic [DW-1:0] dout_dq;
   logic [7:0]    dout_chn;
   logic          sync_out;
   logic          ovf_sticky;

   prach_hbd_ch dut (
      .clk(clk), .rst_n(rst_n), .bypass(bypass), .din_valid(din_valid),
      .din_dp1(din_dp1), .din_dp2(din_dp2), .din_chn(din_chn), .sync_in(sync_in),
      .dout_valid(dout_valid), .dout_dq(dout_dq), .dout_chn(dout_chn),
      .sync_out(sync_out), .ovf_clr(ovf_clr), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit       v;
      bit       s;
      bit [7:0] chn;
      bit       byp;
      int       dq;
      bit       known;
      bit       sat;
   } rec_t;

   rec_t     pipeQ[$];
   int       hist1[$];
   int       hist2[$];
   int       nAsserts = 0;
   int       nFails = 0;
   int       expDq;
   bit       dqKnown;
   bit       expOvf;
   bit       ovfKnown;
   bit [7:0] chnCtr;
   int       satSeq [4] = '{-32768, 32767, 32767, -32768};

   function automatic int rnd16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   task automatic checkVal(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Filter equation evaluated over the list of all accepted slots
   task automatic modelSlot(input bit v, input bit b, input int d1, input int d2,
                            input bit s, input bit [7:0] c, output rec_t r);
      longint acc;
      int     m;
      r = '{default: 0};
      r.v = v; r.s = s; r.chn = c; r.byp = b;
      if (v) begin
         hist1.push_back(d1);
         hist2.push_back(d2);
         m = hist2.size() - 1;
         if (b) begin
            r.dq = d1;
            r.known = 1'b1;
         end else if (m >= (2*U-1)*N) begin
            acc = 0;
            for (int k = 0; k < U; k++)
               acc += longint'(COE[k]) * longint'(hist2[m-k*N] + hist2[m-(2*U-1-k)*N]);
            acc += longint'(hist1[m-(U-1)*N]) * (longint'(1) << (CW-2));
            acc = (acc + (longint'(1) << (CW-2))) >>> (CW-1);
            if (acc > 32767) begin r.dq = 32767; r.sat = 1'b1; end
            else if (acc < -32768) begin r.dq = -32768; r.sat = 1'b1; end
            else r.dq = int'(acc);
            r.known = 1'b1;
         end
      end
   endtask

   task automatic resetModel();
      rec_t z;
      z = '{default: 0};
      pipeQ.delete();
      for (int i = 0; i < 5; i++) pipeQ.push_back(z);
      hist1.delete();
      hist2.delete();
      chnCtr = 0;
      expDq = 0; dqKnown = 1'b1;
      expOvf = 1'b0; ovfKnown = 1'b1;
   endtask

   // Compare the record that entered six cycles ago with the DUT outputs
   task automatic checkOutput(input bit clr);
      rec_t e;
      bit   set, unk;
      e = pipeQ.pop_front();
      checkVal("dout_valid", 32'(dout_valid), 32'(e.v));
      checkVal("dout_chn", 32'(dout_chn), 32'(e.chn));
      checkVal("sync_out", 32'(sync_out), 32'(e.s));
      if (e.v) begin
         if (e.known) begin expDq = e.dq; dqKnown = 1'b1; end
         else dqKnown = 1'b0;
      end
      if (dqKnown) checkVal("dout_dq", 32'($signed(dout_dq)), expDq);
      set = e.v && !e.byp && e.known && e.sat;
      unk = e.v && !e.byp && !e.known;
      if (set) begin
         expOvf = 1'b1; ovfKnown = 1'b1;
      end else if (unk) begin
         if (clr || !(ovfKnown && expOvf)) ovfKnown = 1'b0;
      end else if (clr) begin
         expOvf = 1'b0; ovfKnown = 1'b1;
      end
      if (ovfKnown) checkVal("ovf_sticky", 32'(ovf_sticky), 32'(expOvf));
   endtask

   // Drive one cycle, advance the model at the edge, check just after it
   task automatic applyStimulus(input bit v, input bit b, input int d1, input int d2,
                                input bit s, input bit clr);
      rec_t r;
      din_valid = v; bypass = b; sync_in = s; ovf_clr = clr;
      din_dp1 = DW'(d1); din_dp2 = DW'(d2); din_chn = chnCtr;
      @(posedge clk);
      modelSlot(v, b, d1, d2, s, chnCtr, r);
      pipeQ.push_back(r);
      if (v) chnCtr = (chnCtr == 8'(N-1)) ? 8'd0 : chnCtr + 8'd1;
      #1;
      checkOutput(clr);
   endtask

   // One valid slot, optionally preceded by random idle cycles carrying junk
   task automatic sendSlot(input bit b, input int d1, input int d2, input int gapPct);
      while ($urandom_range(99) < gapPct)
         applyStimulus(1'b0, 1'($urandom_range(1)), rnd16(), rnd16(), 1'($urandom_range(1)), 1'b0);
      applyStimulus(1'b1, b, d1, d2, 1'($urandom_range(1)), 1'b0);
   endtask

   task automatic resetPhase();
      rst_n = 1'b0;
      din_valid = 1'b0; bypass = 1'b0; ovf_clr = 1'b0;
      #1;
      checkVal("rst_dout_valid", 32'(dout_valid), 0);
      checkVal("rst_sync_out", 32'(sync_out), 0);
      checkVal("rst_ovf_sticky", 32'(ovf_sticky), 0);
      checkVal("rst_dout_dq", 32'(dout_dq), 0);
      checkVal("rst_dout_chn", 32'(dout_chn), 0);
      resetModel();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #2;
      resetPhase();

      // Fill history with zeros, then clear any flag raised by unknown history
      for (int f = 0; f < 4; f++) for (int c = 0; c < N; c++) sendSlot(1'b0, 0, 0, 0);
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

      // Impulse on channel 5 odd phase
      for (int f = 0; f < 5; f++)
         for (int c = 0; c < N; c++)
            sendSlot(1'b0, 0, (f == 0 && chnCtr == 8'd5) ? 16384 : 0, 0);

      // Centre tap impulse on channel 0
      for (int f = 0; f < 4; f++)
         for (int c = 0; c < N; c++)
            sendSlot(1'b0, (f == 0 && chnCtr == 8'd0) ? 16384 : 0, 0, 0);

      // DC on every channel
      for (int f = 0; f < 5; f++) for (int c = 0; c < N; c++) sendSlot(1'b0, 10000, 10000, 0);

      // Saturating pattern on channel 3
      for (int f = 0; f < 6; f++)
         for (int c = 0; c < N; c++)
            sendSlot(1'b0, (chnCtr == 8'd3) ? 32767 : 0,
                     (chnCtr == 8'd3 && f < 4) ? satSeq[f] : 0, 0);
      repeat (6) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      checkVal("ovf_after_sat", 32'(ovf_sticky), 1);
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      checkVal("ovf_after_clr", 32'(ovf_sticky), 0);

      // DC and impulse again with random valid gaps
      for (int f = 0; f < 5; f++) for (int c = 0; c < N; c++) sendSlot(1'b0, 10000, 10000, 30);
      for (int f = 0; f < 5; f++)
         for (int c = 0; c < N; c++)
            sendSlot(1'b0, 0, (f == 0 && chnCtr == 8'd5) ? 16384 : 0, 30);

      // Random data with random bypass and gaps
      for (int f = 0; f < 6; f++)
         for (int c = 0; c < N; c++)
            sendSlot($urandom_range(3) == 0, rnd16(), rnd16(), 30);
      applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

      // Single bypass slot
      applyStimulus(1'b1, 1'b1, 1234, rnd16(), 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      checkVal("bypass_1234", 32'($signed(dout_dq)), 1234);

      // Reset in the middle of a stream
      for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, rnd16(), rnd16(), 1'b1, 1'b0);
      #2;
      resetPhase();
      repeat (3) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      for (int f = 0; f < 5; f++)
         for (int c = 0; c < N; c++)
            sendSlot($urandom_range(7) == 0, rnd16(), rnd16(), 10);
      repeat (6) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
